// File: rtl/core_acc_pack_pipe.sv
// core_acc_pack_pipe: MAC -> accumulate -> requantise -> pack -> out-gbus writer.
// Define CORE_ACC_SAT_EN for a saturating accumulator (default wraps).
module core_acc_pack_pipe #(
   parameter int MAC_MULT_NUM    = 16,
   parameter int IDATA_WIDTH     = 8,
   parameter int ACC_WIDTH       = 32,
   parameter int ACC_NUM_WIDTH   = 10,
   parameter int SCALE_WIDTH     = 10,
   parameter int BIAS_WIDTH      = 16,
   parameter int SHIFT_WIDTH     = 5,
   parameter int GBUS_ADDR_WIDTH = 19,
   parameter int WORD_CNT_WIDTH  = 13
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                cfg_vld,
   input  logic [ACC_NUM_WIDTH-1:0]            cfg_acc_num,
   input  logic [SCALE_WIDTH-1:0]              cfg_scale,
   input  logic [BIAS_WIDTH-1:0]               cfg_bias,
   input  logic [SHIFT_WIDTH-1:0]              cfg_shift,
   input  logic                                cfg_raw_mode,
   input  logic [GBUS_ADDR_WIDTH-1:0]          cfg_base_addr,
   input  logic [WORD_CNT_WIDTH-1:0]           cfg_word_num,
   input  logic                                start,
   input  logic [MAC_MULT_NUM*IDATA_WIDTH-1:0] opa,
   input  logic [MAC_MULT_NUM*IDATA_WIDTH-1:0] opb,
   input  logic                                op_vld,
   output logic [GBUS_ADDR_WIDTH-1:0]          out_gbus_addr,
   output logic                                out_gbus_wen,
   output logic [MAC_MULT_NUM*IDATA_WIDTH-1:0] out_gbus_wdata,
   output logic                                busy,
   output logic                                finish
);
   localparam int GW  = MAC_MULT_NUM * IDATA_WIDTH;
   localparam int QW  = ACC_WIDTH + SCALE_WIDTH + 1;
   localparam int PCW = $clog2(MAC_MULT_NUM + 1);
   localparam logic signed [QW-1:0] QMAX = QW'((2 ** (IDATA_WIDTH - 1)) - 1);
   localparam logic signed [QW-1:0] QMIN = ~QMAX;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;

   logic [ACC_NUM_WIDTH-1:0]   acc_num_q, acc_last, acc_cnt;
   logic [SCALE_WIDTH-1:0]     scale_q;
   logic signed [BIAS_WIDTH-1:0] bias_q;
   logic [SHIFT_WIDTH-1:0]     shift_q;
   logic                       raw_q;
   logic [GBUS_ADDR_WIDTH-1:0] base_q, addr;
   logic [WORD_CNT_WIDTH-1:0]  word_num_q, word_last, word_cnt;

   logic signed [2*IDATA_WIDTH-1:0] prod [MAC_MULT_NUM];
   logic signed [ACC_WIDTH-1:0] tree, sum, acc, acc_add, res;
   logic signed [QW-1:0] sc_ext, rnd, q_pre, q_sh;
   logic [IDATA_WIDTH-1:0] q, q_sat;
   logic mv1, mv2, res_vld, qv1, qv;
   logic [GW-1:0] pk, pk_nxt, raw_ext, wr_data;
   logic [PCW-1:0] pk_cnt, pk_cnt_nxt;
   logic run, flush, pk_full, wr_go;

   assign run       = (state == RUN);
   assign busy      = (state != IDLE);
   assign acc_last  = (acc_num_q == '0) ? '0 : acc_num_q - 1'b1;
   assign word_last = (word_num_q == '0) ? '0 : word_num_q - 1'b1;

   always_comb begin
      tree = '0;
      for (int k = 0; k < MAC_MULT_NUM; k++)
         tree = tree + ACC_WIDTH'(prod[k]);
   end

`ifdef CORE_ACC_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   logic signed [ACC_WIDTH:0] acc_wide;
   logic acc_ovf, sat_flg;
   assign acc_wide = {acc[ACC_WIDTH-1], acc} + {sum[ACC_WIDTH-1], sum};
   assign acc_ovf  = acc_wide[ACC_WIDTH] ^ acc_wide[ACC_WIDTH-1];
   assign acc_add  = acc_ovf ? (acc_wide[ACC_WIDTH] ? ~AMAX : AMAX)
                             : acc_wide[ACC_WIDTH-1:0];
   always_ff @(posedge clk) begin
      if (rst) sat_flg <= 1'b0;
      else if (state == IDLE && start) sat_flg <= 1'b0;
      else if (run && mv2 && acc_ovf) sat_flg <= 1'b1;
   end
`else
   assign acc_add = acc + sum;
`endif

   assign sc_ext = $signed(QW'(scale_q));
   assign rnd    = (shift_q == '0) ? '0 : (QW'(1) <<< (shift_q - 1'b1));
   assign q_sh   = q_pre >>> shift_q;
   assign q_sat  = (q_sh > QMAX) ? IDATA_WIDTH'(QMAX) :
                   (q_sh < QMIN) ? IDATA_WIDTH'(QMIN) : q_sh[IDATA_WIDTH-1:0];

   // Insert the new element at the current fill position before deciding to write.
   always_comb begin
      pk_nxt = pk;
      for (int k = 0; k < MAC_MULT_NUM; k++)
         if (qv && pk_cnt == PCW'(k)) pk_nxt[k*IDATA_WIDTH +: IDATA_WIDTH] = q;
      pk_cnt_nxt = pk_cnt + PCW'(qv);
   end

   assign flush   = run & start & ~raw_q;
   assign pk_full = (pk_cnt_nxt == PCW'(MAC_MULT_NUM));
   assign raw_ext = GW'(res);
   assign wr_go   = run & (raw_q ? res_vld : (pk_full | (flush & (pk_cnt_nxt != '0))));
   assign wr_data = raw_q ? raw_ext : pk_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc_num_q <= '0; scale_q <= '0; bias_q <= '0; shift_q <= '0;
         raw_q <= 1'b0; base_q <= '0; word_num_q <= '0;
         addr <= '0; word_cnt <= '0;
         out_gbus_addr <= '0; out_gbus_wen <= 1'b0;
         out_gbus_wdata <= '0; finish <= 1'b0;
      end else begin
         out_gbus_wen <= 1'b0;
         finish <= 1'b0;
         unique case (state)
            IDLE: begin
               word_cnt <= '0;
               if (cfg_vld) begin
                  acc_num_q <= cfg_acc_num; scale_q <= cfg_scale;
                  bias_q <= cfg_bias; shift_q <= cfg_shift;
                  raw_q <= cfg_raw_mode; base_q <= cfg_base_addr;
                  word_num_q <= cfg_word_num;
               end
               if (start) begin
                  state <= RUN;
                  addr <= cfg_vld ? cfg_base_addr : base_q;
               end
            end
            RUN: if (wr_go) begin
               out_gbus_wen <= 1'b1;
               out_gbus_addr <= addr;
               out_gbus_wdata <= wr_data;
               addr <= addr + 1'b1;
               word_cnt <= word_cnt + 1'b1;
               if (word_cnt == word_last) state <= DONE;
            end
            DONE: begin
               finish <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < MAC_MULT_NUM; k++) prod[k] <= '0;
         mv1 <= 1'b0; mv2 <= 1'b0; sum <= '0;
         acc <= '0; acc_cnt <= '0; res <= '0; res_vld <= 1'b0;
         qv1 <= 1'b0; q_pre <= '0; qv <= 1'b0; q <= '0;
         pk <= '0; pk_cnt <= '0;
      end else begin
         for (int k = 0; k < MAC_MULT_NUM; k++)
            prod[k] <= $signed(opa[k*IDATA_WIDTH +: IDATA_WIDTH])
                     * $signed(opb[k*IDATA_WIDTH +: IDATA_WIDTH]);
         mv1 <= run & op_vld;
         mv2 <= run & mv1;
         sum <= tree;
         res_vld <= 1'b0;
         if (!run) begin
            acc <= '0;
            acc_cnt <= '0;
         end else if (mv2) begin
            if (acc_cnt == acc_last) begin
               res <= acc_add;
               res_vld <= 1'b1;
               acc <= '0;
               acc_cnt <= '0;
            end else begin
               acc <= acc_add;
               acc_cnt <= acc_cnt + 1'b1;
            end
         end
         qv1 <= run & res_vld & ~raw_q;
         q_pre <= QW'(res) * sc_ext + (QW'(bias_q) <<< shift_q) + rnd;
         qv <= run & qv1;
         q <= q_sat;
         if (!run || wr_go) begin
            pk <= '0;
            pk_cnt <= '0;
         end else begin
            pk <= pk_nxt;
            pk_cnt <= pk_cnt_nxt;
         end
      end
   end
endmodule
